// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Shift-register scoreboard tracking in-flight writes EX..WB;
//               produces the decode stall, EX forwarding selects and
//               saturating stall/flush performance counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3,
    parameter int SELW       = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rd,
    input  logic              i_id_wr_en,
    input  logic [REG_AW-1:0] i_id_wr_addr,
    input  logic              i_id_is_load,
    input  logic              i_flush,
    input  logic              i_clr_counts,
    output logic              o_stall,
    output logic              o_ex_valid,
    output logic [SELW-1:0]   o_fwd_src_sel,
    output logic [SELW-1:0]   o_fwd_dst_sel,
    output logic [CNT_W-1:0]  o_stall_count,
    output logic [CNT_W-1:0]  o_flush_count
);

    // Write-tracking fields for every stage 1..DEPTH
    logic              r_valid   [1:DEPTH];
    logic              r_wr_en   [1:DEPTH];
    logic [REG_AW-1:0] r_wr_addr [1:DEPTH];
    logic              r_is_load [1:DEPTH];

    // Source fields are only ever consulted in EX, so they are kept for stage 1 only
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_use_rs;
    logic              r_ex_use_rd;

    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic              w_hazard;
    logic              w_accept;

    function automatic int ready_stage(input logic is_load);
        return is_load ? LOAD_READY : ALU_READY;
    endfunction

    always_comb begin
        w_hazard = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            if (r_valid[s] && r_wr_en[s] && ((s + 1) < ready_stage(r_is_load[s])) &&
                ((i_id_use_rs && (i_id_rs == r_wr_addr[s])) ||
                 (i_id_use_rd && (i_id_rd == r_wr_addr[s])))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign o_stall  = i_id_valid & w_hazard & ~i_flush;
    assign w_accept = i_id_valid & ~o_stall & ~i_flush;

    // Scan oldest to youngest so the youngest ready writer is the last assignment
    always_comb begin
        o_fwd_src_sel = '0;
        o_fwd_dst_sel = '0;
        for (int s = DEPTH; s >= 2; s--) begin
            if (r_valid[s] && r_wr_en[s] && (s >= ready_stage(r_is_load[s]))) begin
                if (r_valid[1] && r_ex_use_rs && (r_wr_addr[s] == r_ex_rs)) begin
                    o_fwd_src_sel = SELW'(s);
                end
                if (r_valid[1] && r_ex_use_rd && (r_wr_addr[s] == r_ex_rd)) begin
                    o_fwd_dst_sel = SELW'(s);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int s = 1; s <= DEPTH; s++) begin
                r_valid[s]   <= 1'b0;
                r_wr_en[s]   <= 1'b0;
                r_wr_addr[s] <= '0;
                r_is_load[s] <= 1'b0;
            end
            r_ex_rs     <= '0;
            r_ex_rd     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rd <= 1'b0;
        end else begin
            for (int s = DEPTH; s >= 2; s--) begin
                r_valid[s]   <= r_valid[s-1];
                r_wr_en[s]   <= r_wr_en[s-1];
                r_wr_addr[s] <= r_wr_addr[s-1];
                r_is_load[s] <= r_is_load[s-1];
            end
            r_valid[1]   <= w_accept;
            r_wr_en[1]   <= w_accept & i_id_wr_en;
            r_wr_addr[1] <= w_accept ? i_id_wr_addr : '0;
            r_is_load[1] <= w_accept & i_id_is_load;
            r_ex_rs      <= w_accept ? i_id_rs : '0;
            r_ex_rd      <= w_accept ? i_id_rd : '0;
            r_ex_use_rs  <= w_accept & i_id_use_rs;
            r_ex_use_rd  <= w_accept & i_id_use_rd;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (i_clr_counts) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (o_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (i_flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign o_ex_valid    = r_valid[1];
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed bench for hazard_scoreboard, default configuration
//               plus a DEPTH=4 / LOAD_READY=4 / CNT_W=2 instance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic clk;
    logic RESET;

    // Instance A: default parameters
    logic       a_valid, a_use_rs, a_use_rd, a_wr_en, a_is_load, a_flush, a_clr;
    logic [2:0] a_rs, a_rd, a_wr_addr;
    logic       a_stall, a_ex_valid;
    logic [1:0] a_src, a_dst;
    logic [15:0] a_scnt, a_fcnt;

    // Instance B: DEPTH=4, LOAD_READY=4, SELW=3, CNT_W=2
    logic       b_valid, b_use_rs, b_wr_en, b_is_load;
    logic [2:0] b_rs, b_wr_addr;
    logic       b_stall, b_ex_valid;
    logic [2:0] b_src, b_dst;
    logic [1:0] b_scnt, b_fcnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut_a (
        .clk(clk), .RESET(RESET),
        .i_id_valid(a_valid), .i_id_rs(a_rs), .i_id_rd(a_rd),
        .i_id_use_rs(a_use_rs), .i_id_use_rd(a_use_rd),
        .i_id_wr_en(a_wr_en), .i_id_wr_addr(a_wr_addr), .i_id_is_load(a_is_load),
        .i_flush(a_flush), .i_clr_counts(a_clr),
        .o_stall(a_stall), .o_ex_valid(a_ex_valid),
        .o_fwd_src_sel(a_src), .o_fwd_dst_sel(a_dst),
        .o_stall_count(a_scnt), .o_flush_count(a_fcnt)
    );

    hazard_scoreboard #(
        .REG_AW(3), .DEPTH(4), .ALU_READY(2), .LOAD_READY(4), .SELW(3), .CNT_W(2)
    ) dut_b (
        .clk(clk), .RESET(RESET),
        .i_id_valid(b_valid), .i_id_rs(b_rs), .i_id_rd(3'd0),
        .i_id_use_rs(b_use_rs), .i_id_use_rd(1'b0),
        .i_id_wr_en(b_wr_en), .i_id_wr_addr(b_wr_addr), .i_id_is_load(b_is_load),
        .i_flush(1'b0), .i_clr_counts(1'b0),
        .o_stall(b_stall), .o_ex_valid(b_ex_valid),
        .o_fwd_src_sel(b_src), .o_fwd_dst_sel(b_dst),
        .o_stall_count(b_scnt), .o_flush_count(b_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [2:0] rs, input logic urs,
                         input logic [2:0] rd, input logic urd,
                         input logic we, input logic [2:0] wa, input logic ld);
        a_valid = v; a_rs = rs; a_use_rs = urs; a_rd = rd; a_use_rd = urd;
        a_wr_en = we; a_wr_addr = wa; a_is_load = ld;
        #1;
    endtask

    task automatic drv_b(input logic v, input logic [2:0] rs, input logic urs,
                         input logic we, input logic [2:0] wa, input logic ld);
        b_valid = v; b_rs = rs; b_use_rs = urs;
        b_wr_en = we; b_wr_addr = wa; b_is_load = ld;
        #1;
    endtask

    // Load r3 then a reader of r3 on instance B: two stall cycles, then forward from stage 4
    task automatic b_load_use(input logic [31:0] exp_cnt);
        drv_b(1, 0, 0, 1, 3, 1);
        chk("b_ld_nostall", b_stall, 0);
        tick();
        drv_b(1, 3, 1, 0, 0, 0);
        chk("b_stall_c1", b_stall, 1);
        tick();
        chk("b_stall_c2", b_stall, 1);
        tick();
        chk("b_stall_c3", b_stall, 0);
        tick();
        drv_b(0, 0, 0, 0, 0, 0);
        chk("b_fwd_src", b_src, 4);
        chk("b_ex_valid", b_ex_valid, 1);
        chk("b_stall_count", b_scnt, exp_cnt);
    endtask

    initial begin
        RESET = 1'b1;
        a_flush = 0; a_clr = 0;
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_stall", a_stall, 0);
        chk("rst_ex_valid", a_ex_valid, 0);
        chk("rst_src", a_src, 0);
        chk("rst_dst", a_dst, 0);
        chk("rst_scnt", a_scnt, 0);
        chk("rst_fcnt", a_fcnt, 0);
        tick();
        RESET = 1'b0;

        // Load-use: load r2 then reader of r2
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 2, 1);
        chk("lu_ld_nostall", a_stall, 0);
        tick();
        drv_a(1, 2, 1, 0, 0, 1, 6, 0);
        chk("lu_stall", a_stall, 1);
        chk("lu_scnt0", a_scnt, 0);
        tick();
        chk("lu_stall_end", a_stall, 0);
        chk("lu_scnt1", a_scnt, 1);
        chk("lu_bubble", a_ex_valid, 0);
        tick();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_src", a_src, 3);
        chk("lu_fwd_dst", a_dst, 0);
        chk("lu_ex_valid", a_ex_valid, 1);

        // ALU back-to-back: ADD r5, then reader of r5 as rd, then independent op
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        drv_a(1, 0, 0, 5, 1, 1, 7, 0);
        chk("alu_nostall", a_stall, 0);
        tick();
        drv_a(1, 3, 1, 0, 0, 1, 0, 0);
        chk("alu_fwd_dst", a_dst, 2);
        chk("alu_fwd_src", a_src, 0);
        tick();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        chk("indep_src", a_src, 0);
        chk("indep_dst", a_dst, 0);
        chk("indep_ex_valid", a_ex_valid, 1);

        // Multiple writers of r1: youngest (stage 2) wins
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drv_a(1, 1, 1, 0, 0, 1, 6, 0);
        chk("mw_nostall", a_stall, 0);
        tick();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_fwd_src", a_src, 2);

        // Flush dominates a load-use hazard
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 4, 1);
        tick();
        drv_a(1, 4, 1, 0, 0, 1, 6, 0);
        a_flush = 1;
        #1;
        chk("fl_stall", a_stall, 0);
        tick();
        a_flush = 0;
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_bubble", a_ex_valid, 0);
        chk("fl_fcnt", a_fcnt, 1);
        chk("fl_scnt", a_scnt, 1);

        // Asynchronous reset between edges while stalled; held instruction reissues
        tick();
        drv_a(1, 0, 0, 0, 0, 1, 2, 1);
        tick();
        drv_a(1, 2, 1, 0, 0, 1, 6, 0);
        chk("ar_stall_before", a_stall, 1);
        chk("ar_ex_before", a_ex_valid, 1);
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_stall", a_stall, 0);
        chk("ar_ex_valid", a_ex_valid, 0);
        chk("ar_scnt", a_scnt, 0);
        chk("ar_fcnt", a_fcnt, 0);
        RESET = 1'b0;
        #1;
        chk("ar_stall_rel", a_stall, 0);
        tick();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar_reissue", a_ex_valid, 1);
        chk("ar_reissue_src", a_src, 0);
        chk("ar_scnt_after", a_scnt, 0);

        // Counter clear has priority over a simultaneous flush increment
        a_flush = 1;
        tick();
        chk("clr_fcnt_pre", a_fcnt, 1);
        a_clr = 1;
        tick();
        a_flush = 0;
        a_clr = 0;
        #1;
        chk("clr_fcnt", a_fcnt, 0);

        // Deep configuration: 3 rounds of 2 stalls each, counter saturates at 3
        tick();
        b_load_use(2);
        tick();
        b_load_use(3);
        tick();
        b_load_use(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-stage hazard-detection and forwarding pair.
- Tracks every in-flight register write from EX through WB in a shift-register scoreboard of configurable depth, with per-class result-ready stages.
- Raises the decode stall on any not-yet-forwardable dependency and produces forwarding selects for the instruction in EX.
- Sits between decode and execute; also keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 3, register address width (NUM_REGS = 2**REG_AW).
- DEPTH, 3, tracked stages after decode: stage 1 = EX … stage DEPTH = WB; minimum 2.
- ALU_READY, 2, first stage from which a non-load result is forwardable; 2 ≤ ALU_READY ≤ DEPTH.
- LOAD_READY, 3, first stage from which load data is forwardable; ALU_READY ≤ LOAD_READY ≤ DEPTH.
- SELW, 2, forwarding-select width; must satisfy 2**SELW > DEPTH.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  REG_AW  source register address.
- id_rd  in  REG_AW  destination-as-source register address.
- id_use_rs  in  1  instruction reads rs.
- id_use_rd  in  1  instruction reads rd.
- id_wr_en  in  1  instruction writes a register.
- id_wr_addr  in  REG_AW  written register address.
- id_is_load  in  1  write data comes from memory.
- flush  in  1  branch/jump taken in EX; kill the decode instruction.
- clr_counts  in  1  synchronous clear of both counters.
- stall  out  1  hold PC and fetch/decode register; insert a bubble.
- ex_valid  out  1  stage-1 (EX) entry is valid.
- fwd_src_sel  out  SELW  EX rs source: 0 = register-file/decode value; s = stage s result.
- fwd_dst_sel  out  SELW  EX rd source, same encoding.
- stall_count  out  CNT_W  cycles with stall=1, saturating.
- flush_count  out  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Entry fields: valid, rs, rd, use_rs, use_rd, wr_en, wr_addr, is_load. Every clock all entries shift stage s → s+1; the entry leaving stage DEPTH is discarded. Stages never stall behind decode.
- Stage-1 load: the decode entry when id_valid & ~stall & ~flush; otherwise a bubble (valid=0, all flags 0).
- Ready stage per entry: R = LOAD_READY if is_load, else ALU_READY.
- Hazard, combinational: exists stage s, 1 ≤ s ≤ DEPTH, where the entry is valid & wr_en, (s+1) < R, and (id_use_rs & id_rs==wr_addr) | (id_use_rd & id_rd==wr_addr).
- stall = id_valid & hazard & ~flush. Flush dominates.
- Forwarding, for the stage-1 entry only: fwd_src_sel = smallest s in 2..DEPTH with the entry valid & wr_en & wr_addr==rs & s ≥ R; 0 if none or use_rs=0. fwd_dst_sel is the same using rd/use_rd.
- The youngest match wins on multiple writers of the same register. Invalid stage 1 gives both selects 0.
- A not-yet-ready match in stages ≥ 2 cannot occur when the stall is correct. If it does (illegal), that stage is skipped for forwarding.
- Address 0 is not special: it is tracked and forwarded like any register.
- stall_count increments on stall; flush_count increments on flush. Both saturate at 2**CNT_W−1 and do not wrap. clr_counts has priority over increment.
- RESET (any time, including mid-stall): all entries invalid. stall=0, ex_valid=0, fwd_*_sel=0, both counters 0.
- First clock after release accepts decode normally.
- Latency: stall and selects are combinational from inputs/state. Scoreboard state updates one cycle after the decode inputs.

Test Plan:
- Load-use, defaults: load writing r2 issued, then dependent (id_use_rs=1, id_rs=2) in decode → stall=1 for exactly 1 cycle, stall_count=1. Next cycle fwd_src_sel=3 with ex_valid=1.
- ALU back-to-back: ADD writes r5, then next reads r5 as rd → no stall; in EX fwd_dst_sel=2. Independent next op → selects 0.
- Multiple writers: r1 written by consecutive ALU ops A, B, then reader C → fwd_src_sel=2 (B), not 3 (A).
- Flush over hazard: load r4 in EX, dependent in decode, flush=1 same cycle → stall=0, bubble enters EX (ex_valid=0 next cycle), flush_count=1.
- Parametrised config DEPTH=4, LOAD_READY=4: load r3 followed by reader → stall for 2 cycles, then fwd_src_sel=4. Saturation with CNT_W=2: 5 stall cycles → stall_count=3.
- Async reset mid-stall: assert RESET between edges while stall=1 → stall=0, counters 0, ex_valid=0 immediately. The held instruction reissues without stall.
